// File: rtl/axi_lite_master_pkg.sv
// Shared types and constants for the AXI-lite burst master: FSM states,
// write-response codes and default bus widths.
package axi_lite_master_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_LEN_W  = 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AW   = 3'd1,
    ST_W    = 3'd2,
    ST_B    = 3'd3,
    ST_AR   = 3'd4,
    ST_R    = 3'd5,
    ST_DONE = 3'd6
  } state_e;

endpackage

// File: rtl/axi_watchdog.sv
// Stall watchdog: counts enabled cycles since the last kick and flags expire
// once LIMIT cycles have elapsed; the count holds at LIMIT until kicked.
module axi_watchdog #(
  parameter int LIMIT = 1024
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic en,
  input  logic kick,
  output logic expire
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge aclk) begin
    if (!aresetn || !en || kick)
      cnt_q <= '0;
    else if (cnt_q != CW'(LIMIT))
      cnt_q <= cnt_q + CW'(1);
  end

  assign expire = en & (cnt_q == CW'(LIMIT));

endmodule

// File: rtl/axi_lite_burst_master.sv
// Command-driven AXI-lite burst engine (wlast/rlast extension) with streamed
// write/read data. Optional stuck-slave watchdog: define AXI_MASTER_TIMEOUT_EN.
module axi_lite_burst_master
  import axi_lite_master_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int LEN_W       = DEF_LEN_W,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              done,
  output logic              err,
  output logic              timeout,
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic              wvalid,
  input  logic              wready,
  output logic              wlast,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rvalid,
  output logic              rready,
  input  logic              rlast
);

  state_e            st, st_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q, beat_q;
  logic              cmd_ready_q, err_q;
  logic              expire;
  logic              in_aw, in_w, in_b, in_ar, in_r;
  logic              last_beat;
  logic              hs_cmd, hs_aw, hs_w, hs_b, hs_ar, hs_r, r_end;

  // Expiry masks every bus-facing valid/ready in the same cycle it fires.
  assign in_aw = (st == ST_AW) & ~expire;
  assign in_w  = (st == ST_W)  & ~expire;
  assign in_b  = (st == ST_B)  & ~expire;
  assign in_ar = (st == ST_AR) & ~expire;
  assign in_r  = (st == ST_R)  & ~expire;

  assign last_beat = (beat_q == len_q - LEN_W'(1));

  assign cmd_ready = cmd_ready_q;
  assign awaddr    = addr_q;
  assign araddr    = addr_q;
  assign awvalid   = in_aw;
  assign wvalid    = in_w & wr_valid;
  assign wdata     = in_w ? wr_data : '0;
  assign wr_ready  = in_w & wready;
  assign wlast     = in_w & last_beat;
  assign bready    = in_b;
  assign arvalid   = in_ar;
  assign rready    = in_r & rd_ready;
  assign rd_valid  = in_r & rvalid;
  assign rd_data   = in_r ? rdata : '0;
  assign rd_last   = rd_valid & (rlast | last_beat);
  assign done      = (st == ST_DONE);
  assign err       = err_q;

  assign hs_cmd = cmd_valid & cmd_ready_q;
  assign hs_aw  = awvalid & awready;
  assign hs_w   = wvalid & wready;
  assign hs_b   = bvalid & bready;
  assign hs_ar  = arvalid & arready;
  assign hs_r   = rvalid & rready;
  assign r_end  = hs_r & (rlast | last_beat);

  always_comb begin
    st_nxt = st;
    case (st)
      ST_IDLE: if (hs_cmd) st_nxt = cmd_write ? ST_AW : ST_AR;
      ST_AW:   if (expire) st_nxt = ST_DONE; else if (hs_aw) st_nxt = ST_W;
      ST_W:    if (expire) st_nxt = ST_DONE; else if (hs_w && last_beat) st_nxt = ST_B;
      ST_B:    if (expire || hs_b) st_nxt = ST_DONE;
      ST_AR:   if (expire) st_nxt = ST_DONE; else if (hs_ar) st_nxt = ST_R;
      ST_R:    if (expire || r_end) st_nxt = ST_DONE;
      ST_DONE: st_nxt = ST_IDLE;
      default: st_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      st          <= ST_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      cmd_ready_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      st          <= st_nxt;
      cmd_ready_q <= (st_nxt == ST_IDLE);
      if (hs_cmd) begin
        addr_q <= cmd_addr;
        len_q  <= (cmd_len == '0) ? LEN_W'(1) : cmd_len;
        beat_q <= '0;
        err_q  <= 1'b0;
      end
      if (hs_w || hs_r) beat_q <= beat_q + LEN_W'(1);
      if (hs_b) err_q <= (bresp != RESP_OKAY);
      // A read that ends on only one of rlast / beat count is a length mismatch.
      if (r_end) err_q <= (rlast != last_beat);
      if (expire) err_q <= 1'b1;
    end
  end

`ifdef AXI_MASTER_TIMEOUT_EN
  logic wd_en, wd_kick, timeout_q;

  assign wd_en   = (st == ST_AW) | (st == ST_W) | (st == ST_B) | (st == ST_AR) | (st == ST_R);
  assign wd_kick = (st_nxt != st) | hs_aw | hs_w | hs_b | hs_ar | hs_r;

  axi_watchdog #(.LIMIT(TIMEOUT_CYC)) u_wd (
    .aclk    (aclk),
    .aresetn (aresetn),
    .en      (wd_en),
    .kick    (wd_kick),
    .expire  (expire)
  );

  always_ff @(posedge aclk) begin
    if (!aresetn)    timeout_q <= 1'b0;
    else if (hs_cmd) timeout_q <= 1'b0;
    else if (expire) timeout_q <= 1'b1;
  end

  assign timeout = timeout_q;
`else
  // Keeps TIMEOUT_CYC referenced when the watchdog is compiled out.
  assign expire  = 1'b0 & (TIMEOUT_CYC != 0);
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_axi_lite_burst_master.sv
// Directed bench for axi_lite_burst_master: write/read bursts, backpressure,
// early rlast, mid-burst reset and (when compiled in) the watchdog.
module tb_axi_lite_burst_master;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic        wr_valid = 1'b0, wr_ready;
  logic [31:0] wr_data = '0;
  logic        rd_valid, rd_ready = 1'b0, rd_last;
  logic [31:0] rd_data;
  logic        done, err, timeout;
  logic [31:0] awaddr, wdata, araddr, rdata = '0;
  logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0, wlast;
  logic [1:0]  bresp = 2'b00;
  logic        bvalid = 1'b0, bready, arvalid, arready = 1'b0;
  logic        rvalid = 1'b0, rready, rlast = 1'b0;

  always #5 aclk = ~aclk;

  axi_lite_burst_master #(.ADDR_W(32), .DATA_W(32), .LEN_W(8), .TIMEOUT_CYC(16)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .done(done), .err(err), .timeout(timeout),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wvalid(wvalid), .wready(wready), .wlast(wlast),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready), .rlast(rlast)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Observations from the last burst.
  logic [31:0] wq[$];
  bit          wlq[$];
  logic [31:0] rq[$];
  bit          rlq[$];
  int          done_cyc, aw_drop_cyc;
  bit          done_seen, err_d, to_d, rst_hit;
  logic [31:0] aw_addr_seen, ar_addr_seen;

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [7:0] len);
    int n = 0;
    @(negedge aclk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
    #1;
    while (!cmd_ready && n < 20) begin
      @(negedge aclk); #1; n++;
    end
    if (!cmd_ready) begin
      n_checks++; n_fail++;
      $display("FAIL cmd_accept: cmd_ready=%0b after %0d cycles, required 1", cmd_ready, n);
    end
  endtask

  // Cycle 1 is the first cycle after the command handshake edge.
  task automatic run_burst(input logic [31:0] wbase, input bit wr_toggle, input int rlast_at,
                           input int stall_beat, input int rst_at_beat, input bit aw_stuck,
                           input int budget);
    int cyc = 0, w_idx = 0, r_idx = 0, stall = 0;
    bit aw_was = 1'b0;
    wq.delete(); wlq.delete(); rq.delete(); rlq.delete();
    done_seen = 0; done_cyc = -1; aw_drop_cyc = -1; err_d = 0; to_d = 0; rst_hit = 0;
    aw_addr_seen = 'x; ar_addr_seen = 'x;
    while (!done_seen && cyc < budget) begin
      @(negedge aclk); cyc++;
      cmd_valid = 1'b0;
      awready  = !aw_stuck;
      arready  = 1'b1;
      bvalid   = 1'b1;
      wready   = wr_toggle ? (cyc % 2 == 1) : 1'b1;
      wr_valid = 1'b1;
      wr_data  = wbase + w_idx;
      rvalid   = 1'b1;
      rdata    = 32'hA0 + r_idx;
      rlast    = (r_idx == rlast_at);
      rd_ready = !(r_idx == stall_beat && stall < 3);
      #1;
      if (rst_at_beat >= 0 && wvalid && w_idx == rst_at_beat) begin
        aresetn = 1'b0; rst_hit = 1; return;
      end
      if (awvalid && !aw_was) aw_addr_seen = awaddr;
      if (aw_was && !awvalid && aw_drop_cyc < 0) aw_drop_cyc = cyc;
      aw_was = awvalid;
      if (arvalid) ar_addr_seen = araddr;
      if (wvalid && wready) begin wq.push_back(wdata); wlq.push_back(wlast); w_idx++; end
      if (rd_valid && rd_ready) begin rq.push_back(rd_data); rlq.push_back(rd_last); r_idx++; end
      if (rd_valid && !rd_ready) stall++;
      if (done) begin done_seen = 1; done_cyc = cyc; err_d = err; to_d = timeout; end
    end
    if (!done_seen) begin
      n_checks++; n_fail++;
      $display("FAIL burst_done: no done within %0d cycles", budget);
    end
  endtask

  task automatic test_reset;
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    #1;
    n_checks++;
    if ({cmd_ready, awvalid, wvalid, wlast, wr_ready, bready, arvalid, rready,
         rd_valid, rd_last, done, err, timeout} !== 13'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b required all 0", {cmd_ready, awvalid, wvalid, wlast,
               wr_ready, bready, arvalid, rready, rd_valid, rd_last, done, err, timeout});
    end
    n_checks++;
    if ({awaddr, araddr, wdata, rd_data} !== 128'b0) begin
      n_fail++;
      $display("FAIL reset_data: awaddr=%h araddr=%h wdata=%h rd_data=%h required 0",
               awaddr, araddr, wdata, rd_data);
    end
    aresetn = 1'b1;
    @(negedge aclk); #1;
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_ready: cmd_ready=%b required 1", cmd_ready);
    end
  endtask

  task automatic test_write_single;
    bresp = 2'b00;
    issue(1'b1, 32'h0000_0010, 8'd1);
    run_burst(32'h3, 1'b0, -1, -1, -1, 1'b0, 20);
    n_checks++;
    if (aw_addr_seen !== 32'h10) begin n_fail++; $display("FAIL wr1_awaddr: got %h required 00000010", aw_addr_seen); end
    n_checks++;
    if (wq.size() !== 1) begin n_fail++; $display("FAIL wr1_beats: got %0d required 1", wq.size()); end
    else begin
      n_checks++;
      if (wq[0] !== 32'h3 || wlq[0] !== 1'b1) begin
        n_fail++; $display("FAIL wr1_beat0: data=%h wlast=%b required 00000003/1", wq[0], wlq[0]);
      end
    end
    n_checks++;
    if (done_cyc !== 4) begin n_fail++; $display("FAIL wr1_done_cycle: got %0d required 4", done_cyc); end
    n_checks++;
    if (err_d !== 1'b0 || to_d !== 1'b0) begin n_fail++; $display("FAIL wr1_status: err=%b timeout=%b required 0/0", err_d, to_d); end
  endtask

  task automatic test_write_backpressure;
    bresp = 2'b10;
    issue(1'b1, 32'h0000_0100, 8'd5);
    run_burst(32'h1234_5678, 1'b1, -1, -1, -1, 1'b0, 40);
    n_checks++;
    if (wq.size() !== 5) begin n_fail++; $display("FAIL wr5_beats: got %0d required 5", wq.size()); end
    else begin
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (wq[i] !== 32'h1234_5678 + i || wlq[i] !== (i == 4)) begin
          n_fail++;
          $display("FAIL wr5_beat%0d: data=%h wlast=%b required %h/%0b", i, wq[i], wlq[i],
                   32'h1234_5678 + i, (i == 4));
        end
      end
    end
    n_checks++;
    if (err_d !== 1'b1) begin n_fail++; $display("FAIL wr5_slverr: err=%b required 1", err_d); end
    bresp = 2'b00;
  endtask

  task automatic test_read_stall;
    issue(1'b0, 32'h0000_2000, 8'd4);
    run_burst(32'h0, 1'b0, 3, 1, -1, 1'b0, 40);
    n_checks++;
    if (ar_addr_seen !== 32'h2000) begin n_fail++; $display("FAIL rd4_araddr: got %h required 00002000", ar_addr_seen); end
    n_checks++;
    if (rq.size() !== 4) begin n_fail++; $display("FAIL rd4_beats: got %0d required 4", rq.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (rq[i] !== 32'hA0 + i || rlq[i] !== (i == 3)) begin
          n_fail++;
          $display("FAIL rd4_beat%0d: data=%h rd_last=%b required %h/%0b", i, rq[i], rlq[i],
                   32'hA0 + i, (i == 3));
        end
      end
    end
    n_checks++;
    if (done_cyc !== 9) begin n_fail++; $display("FAIL rd4_done_cycle: got %0d required 9", done_cyc); end
    n_checks++;
    if (err_d !== 1'b0) begin n_fail++; $display("FAIL rd4_err: got %b required 0", err_d); end
  endtask

  task automatic test_read_early_rlast;
    issue(1'b0, 32'h0000_3000, 8'd4);
    run_burst(32'h0, 1'b0, 1, -1, -1, 1'b0, 20);
    n_checks++;
    if (rq.size() !== 2) begin n_fail++; $display("FAIL rdearly_beats: got %0d required 2", rq.size()); end
    else begin
      n_checks++;
      if (rq[1] !== 32'hA1 || rlq[0] !== 1'b0 || rlq[1] !== 1'b1) begin
        n_fail++;
        $display("FAIL rdearly_last: data=%h rd_last=%b%b required 000000a1/01", rq[1], rlq[0], rlq[1]);
      end
    end
    n_checks++;
    if (done_cyc !== 4 || err_d !== 1'b1) begin
      n_fail++; $display("FAIL rdearly_status: done_cyc=%0d err=%b required 4/1", done_cyc, err_d);
    end
  endtask

  task automatic test_back_to_back;
    issue(1'b1, 32'h0000_0040, 8'd0);
    run_burst(32'hCAFE_0000, 1'b0, -1, -1, -1, 1'b0, 20);
    n_checks++;
    if (wq.size() !== 1 || done_cyc !== 4) begin
      n_fail++; $display("FAIL len0_write: beats=%0d done_cyc=%0d required 1/4", wq.size(), done_cyc);
    end
    else begin
      n_checks++;
      if (wlq[0] !== 1'b1) begin n_fail++; $display("FAIL len0_wlast: got %b required 1", wlq[0]); end
    end
    @(negedge aclk); #1;
    n_checks++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: cmd_ready=%b required 1", cmd_ready); end
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0080; cmd_len = 8'd2;
    run_burst(32'h0, 1'b0, 1, -1, -1, 1'b0, 20);
    n_checks++;
    if (rq.size() !== 2 || done_cyc !== 4 || err_d !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_read: beats=%0d done_cyc=%0d err=%b required 2/4/0", rq.size(), done_cyc, err_d);
    end
  endtask

  task automatic test_timeout;
`ifdef AXI_MASTER_TIMEOUT_EN
    issue(1'b1, 32'h0000_0500, 8'd1);
    run_burst(32'h0, 1'b0, -1, -1, -1, 1'b1, 40);
    n_checks++;
    if (aw_drop_cyc !== 17) begin n_fail++; $display("FAIL to_aw_drop: got %0d required 17", aw_drop_cyc); end
    n_checks++;
    if (done_cyc !== 18 || err_d !== 1'b1 || to_d !== 1'b1) begin
      n_fail++;
      $display("FAIL to_status: done_cyc=%0d err=%b timeout=%b required 18/1/1", done_cyc, err_d, to_d);
    end
    issue(1'b1, 32'h0000_0600, 8'd1);
    run_burst(32'h5, 1'b0, -1, -1, -1, 1'b0, 20);
    n_checks++;
    if (done_cyc !== 4 || err_d !== 1'b0 || to_d !== 1'b0) begin
      n_fail++;
      $display("FAIL to_recover: done_cyc=%0d err=%b timeout=%b required 4/0/0", done_cyc, err_d, to_d);
    end
`endif
  endtask

  task automatic test_reset_mid_burst;
    issue(1'b1, 32'h0000_0700, 8'd8);
    run_burst(32'h100, 1'b0, -1, -1, 2, 1'b0, 30);
    n_checks++;
    if (!rst_hit || done_seen || wq.size() !== 2) begin
      n_fail++;
      $display("FAIL midrst_inject: hit=%b done=%b beats=%0d required 1/0/2", rst_hit, done_seen, wq.size());
    end
    @(negedge aclk); #1;
    n_checks++;
    if ({cmd_ready, awvalid, wvalid, wlast, wr_ready, bready, arvalid, rready,
         rd_valid, rd_last, done, err, timeout} !== 13'b0 ||
        {awaddr, araddr, wdata, rd_data} !== 128'b0) begin
      n_fail++;
      $display("FAIL midrst_outputs: wvalid=%b wr_ready=%b wlast=%b done=%b awaddr=%h wdata=%h required 0",
               wvalid, wr_ready, wlast, done, awaddr, wdata);
    end
    aresetn = 1'b1;
    issue(1'b1, 32'h0000_0800, 8'd2);
    run_burst(32'h200, 1'b0, -1, -1, -1, 1'b0, 20);
    n_checks++;
    if (wq.size() !== 2 || done_cyc !== 5 || err_d !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_recover: beats=%0d done_cyc=%0d err=%b required 2/5/0", wq.size(), done_cyc, err_d);
    end
    else begin
      n_checks++;
      if (wq[0] !== 32'h200 || wq[1] !== 32'h201) begin
        n_fail++; $display("FAIL midrst_data: got %h %h required 00000200 00000201", wq[0], wq[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_single();
    test_write_backpressure();
    test_read_stall();
    test_read_early_rlast();
    test_back_to_back();
    test_timeout();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
